// File: rtl/mips_imem_loader_pkg.sv
// Shared types and constants for the MIPS imem byte-stream loader.
// Optional checksum trailer is enabled by MIPS_LOADER_CKSUM_EN.
package mips_imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR0  = 3'd1,
        HDR1  = 3'd2,
        DATA  = 3'd3,
        CKSUM = 3'd4,
        RUN   = 3'd5,
        ERROR = 3'd6
    } loader_state_t;

    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;

    typedef struct packed {
        logic in_ready;
        logic busy;
        logic done;
        logic error;
        logic cpu_rst_n;
    } loader_flags_t;

    // Status outputs implied by the state being entered.
    function automatic loader_flags_t state_flags(input loader_state_t s);
        loader_flags_t f;
        f = 5'b0_0000;
        case (s)
            HDR0, HDR1, DATA, CKSUM: begin
                f.in_ready = 1'b1;
                f.busy     = 1'b1;
            end
            RUN: begin
                f.done      = 1'b1;
                f.cpu_rst_n = 1'b1;
            end
            ERROR:   f.error = 1'b1;
            default: f = 5'b0_0000;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/mips_imem_loader_word_assembler.sv
// Packs little-endian stream bytes into instruction words.
// Byte k of a word lands in bits [8k+7:8k]; word_valid flags the final byte.
module mips_word_assembler
    import mips_imem_loader_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_clear,
    input  logic                  i_byte_en,
    input  logic [7:0]            i_byte,
    output logic                  o_word_valid,
    output logic [DATA_WIDTH-1:0] o_word
);

    localparam int IW = $clog2(BYTES_PER_WORD);

    logic [IW-1:0]         r_byte_idx;
    logic [DATA_WIDTH-9:0] r_shift;

    assign o_word_valid = i_byte_en && (r_byte_idx == IW'(BYTES_PER_WORD - 1));
    assign o_word       = {i_byte, r_shift};

    // Byte index and shift register; new bytes enter at the top so byte 0 ends lowest.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_byte_idx <= {IW{1'b0}};
            r_shift    <= {(DATA_WIDTH-8){1'b0}};
        end else if (i_clear) begin
            r_byte_idx <= {IW{1'b0}};
            r_shift    <= {(DATA_WIDTH-8){1'b0}};
        end else if (i_byte_en) begin
            r_shift    <= o_word[DATA_WIDTH-1:8];
            r_byte_idx <= o_word_valid ? {IW{1'b0}} : r_byte_idx + IW'(1);
        end
    end

endmodule

// File: rtl/mips_imem_loader.sv
// Instruction-memory loader: header (2-byte count) + words, holds the core in reset until done.
// Define MIPS_LOADER_CKSUM_EN to require a trailing XOR checksum byte.
module mips_imem_loader
    import mips_imem_loader_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int PC_WIDTH   = 16,
    parameter int MEM_SIZE   = 256
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic                  i_in_valid,
    input  logic [7:0]            i_in_data,
    output logic                  o_in_ready,
    output logic                  o_imem_we,
    output logic [PC_WIDTH-1:0]   o_imem_addr,
    output logic [DATA_WIDTH-1:0] o_imem_wdata,
    output logic                  o_cpu_rst_n,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_error
);

    loader_state_t         r_state;
    loader_flags_t         r_flags;
    logic [15:0]           r_count;
    logic [PC_WIDTH-1:0]   r_word_idx;
    logic                  r_last_wr;
    logic                  r_imem_we;
    logic [PC_WIDTH-1:0]   r_imem_addr;
    logic [DATA_WIDTH-1:0] r_imem_wdata;
`ifdef MIPS_LOADER_CKSUM_EN
    logic [7:0]            r_cksum;
`endif

    logic                  w_accept;
    logic                  w_start_ok;
    logic [15:0]           w_hdr_count;
    logic                  w_hdr_bad;
    logic                  w_clear;
    logic                  w_byte_en;
    logic                  w_last_word;
    logic                  w_word_valid;
    logic [DATA_WIDTH-1:0] w_word;

    assign w_accept    = i_in_valid && r_flags.in_ready;
    assign w_start_ok  = i_start && ((r_state == IDLE) || (r_state == RUN) || (r_state == ERROR));
    assign w_hdr_count = {i_in_data, r_count[7:0]};
    assign w_hdr_bad   = (w_hdr_count == 16'd0) || (32'(w_hdr_count) > 32'(MEM_SIZE));
    assign w_clear     = (r_state == HDR1) && w_accept;
    assign w_byte_en   = (r_state == DATA) && w_accept;
    assign w_last_word = (r_word_idx == PC_WIDTH'(r_count - 16'd1));

    mips_word_assembler #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_word_asm (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_clear      (w_clear),
        .i_byte_en    (w_byte_en),
        .i_byte       (i_in_data),
        .o_word_valid (w_word_valid),
        .o_word       (w_word)
    );

    // Loader FSM with registered status flags and imem write port.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_flags      <= 5'b0_0000;
            r_count      <= 16'd0;
            r_word_idx   <= {PC_WIDTH{1'b0}};
            r_last_wr    <= 1'b0;
            r_imem_we    <= 1'b0;
            r_imem_addr  <= {PC_WIDTH{1'b0}};
            r_imem_wdata <= {DATA_WIDTH{1'b0}};
`ifdef MIPS_LOADER_CKSUM_EN
            r_cksum      <= 8'd0;
`endif
        end else begin
            r_imem_we <= 1'b0;
            if (w_start_ok) begin
                r_state <= HDR0;
                r_flags <= state_flags(HDR0);
            end else begin
                case (r_state)
                    HDR0: begin
                        if (w_accept) begin
                            r_count[7:0] <= i_in_data;
                            r_state      <= HDR1;
                        end
                    end
                    HDR1: begin
                        if (w_accept) begin
                            r_count[15:8] <= i_in_data;
                            if (w_hdr_bad) begin
                                r_state <= ERROR;
                                r_flags <= state_flags(ERROR);
                            end else begin
                                r_word_idx <= {PC_WIDTH{1'b0}};
                                r_last_wr  <= 1'b0;
`ifdef MIPS_LOADER_CKSUM_EN
                                r_cksum    <= 8'd0;
`endif
                                r_state    <= DATA;
                            end
                        end
                    end
                    DATA: begin
                        // The final write gets its own cycle with the stream paused.
                        if (r_last_wr) begin
                            r_last_wr <= 1'b0;
`ifdef MIPS_LOADER_CKSUM_EN
                            r_state   <= CKSUM;
                            r_flags   <= state_flags(CKSUM);
`else
                            r_state   <= RUN;
                            r_flags   <= state_flags(RUN);
`endif
                        end else if (w_byte_en) begin
`ifdef MIPS_LOADER_CKSUM_EN
                            r_cksum <= r_cksum ^ i_in_data;
`endif
                            if (w_word_valid) begin
                                r_imem_we    <= 1'b1;
                                r_imem_addr  <= r_word_idx;
                                r_imem_wdata <= w_word;
                                r_word_idx   <= r_word_idx + PC_WIDTH'(1);
                                if (w_last_word) begin
                                    r_last_wr        <= 1'b1;
                                    r_flags.in_ready <= 1'b0;
                                end
                            end
                        end
                    end
`ifdef MIPS_LOADER_CKSUM_EN
                    CKSUM: begin
                        if (w_accept) begin
                            if (i_in_data == r_cksum) begin
                                r_state <= RUN;
                                r_flags <= state_flags(RUN);
                            end else begin
                                r_state <= ERROR;
                                r_flags <= state_flags(ERROR);
                            end
                        end
                    end
`endif
                    IDLE, RUN, ERROR: begin
                        r_state <= r_state;
                    end
                    default: begin
                        r_state <= IDLE;
                        r_flags <= state_flags(IDLE);
                    end
                endcase
            end
        end
    end

    assign o_in_ready   = r_flags.in_ready;
    assign o_busy       = r_flags.busy;
    assign o_done       = r_flags.done;
    assign o_error      = r_flags.error;
    assign o_cpu_rst_n  = r_flags.cpu_rst_n;
    assign o_imem_we    = r_imem_we;
    assign o_imem_addr  = r_imem_addr;
    assign o_imem_wdata = r_imem_wdata;

endmodule
